// File: rtl/stream_accumulator.sv
// rtl/stream_accumulator.sv - packet sum/term-count accumulator on valid/ready streams (option: ACC_SIGNED_EN)
module stream_accumulator #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 4,
    parameter int ACC_W   = DATA_W + COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [COUNT_W:0]   out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [COUNT_W:0] MAX_TERMS = (COUNT_W + 1)'(1) << COUNT_W;
    localparam logic [COUNT_W:0] ONE       = (COUNT_W + 1)'(1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W:0]   count_q, count_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [COUNT_W:0]   out_count_q, out_count_d;

    logic [ACC_W-1:0]   ext_data;
    logic [ACC_W-1:0]   sum_next;
    logic [COUNT_W:0]   count_next;
    logic               beat;

    // Widen the operand to accumulator width (sign- or zero-extension by build)
    always_comb begin
`ifdef ACC_SIGNED_EN
        ext_data = ACC_W'($signed(in_data));
`else
        ext_data = ACC_W'(in_data);
`endif
    end

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign beat      = in_valid && in_ready;

    // Next-state logic: start/extend the packet on a beat, close on last or full, release on out_ready
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        sum_next    = (state_q == IDLE) ? ext_data : (acc_q + ext_data);
        count_next  = (state_q == IDLE) ? ONE : (count_q + ONE);

        case (state_q)
            IDLE, ACCUM: begin
                if (beat) begin
                    acc_d   = sum_next;
                    count_d = count_next;
                    if (in_last || (count_next == MAX_TERMS)) begin
                        state_d     = HOLD;
                        out_sum_d   = sum_next;
                        out_count_d = count_next;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                count_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
        end
    end

endmodule

// File: tb/tb_stream_accumulator.sv
// tb/tb_stream_accumulator.sv - self-checking bench for stream_accumulator
module tb_stream_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [4:0]  out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       r;
        logic       e_rdy;
        logic       e_ov;
        int         e_sum;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];

`ifdef ACC_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic check_out(input string tag, input int rdy, input int ov, input int sum, input int cnt);
        chk({tag, "_in_ready"}, int'(in_ready), rdy);
        chk({tag, "_out_valid"}, int'(out_valid), ov);
        chk({tag, "_out_sum"}, int'(out_sum), sum);
        chk({tag, "_out_count"}, int'(out_count), cnt);
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic l, input logic r,
                       input logic e_rdy, input logic e_ov, input int e_sum, input int e_cnt);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.r = r;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_sum = e_sum; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    function automatic int beat_value(input logic [7:0] d);
        if (SIGNED_BUILD) return int'($signed(d));
        return int'(d);
    endfunction

    // Random-phase model state: accepted beats of the open packet and the pending result
    int  pkt_q[$];
    bit  pending;
    int  exp_sum, exp_cnt;
    bit  hold_beat;
    logic       cur_v, cur_l;
    logic [7:0] cur_d;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #3;
        check_out("reset", 1, 0, 0, 0);
        #14 rst_n = 1'b1;
        step();
        check_out("post_reset", 1, 0, 0, 0);

        // Basic packet, backpressure, single beat with garbage gaps, gap inside a packet
        add(1, 8'd10, 0, 0,   1, 0,   0, 0);
        add(1, 8'd20, 0, 0,   1, 0,   0, 0);
        add(1, 8'd30, 1, 0,   0, 1,  60, 3);
        for (int i = 0; i < 5; i++) add(1, 8'd99, 1, 0,   0, 1, 60, 3);
        add(0, 8'd0,  0, 1,   1, 0,  60, 3);
        for (int i = 0; i < 3; i++) add(0, 8'hAB, 1, 1,   1, 0, 60, 3);
        add(1, 8'd7,  1, 0,   0, 1,   7, 1);
        add(0, 8'd0,  0, 1,   1, 0,   7, 1);
        add(1, 8'd10, 0, 1,   1, 0,   7, 1);
        add(1, 8'd20, 0, 1,   1, 0,   7, 1);
        add(1, 8'd30, 1, 1,   0, 1,  60, 3);
        add(0, 8'd0,  0, 1,   1, 0,  60, 3);
        add(1, 8'd100, 0, 1,  1, 0,  60, 3);
        add(0, 8'd5,  1, 1,   1, 0,  60, 3);
        add(1, 8'd27, 1, 0,   0, 1, 127, 2);
        add(0, 8'd0,  0, 1,   1, 0, 127, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_sum, vecs[i].e_cnt);
        end

        // Auto-close after 16 beats of 8'hFF (4080 unsigned, -16 signed: both 12'hFF0)
        for (int k = 0; k < 16; k++) begin
            drive(1, 8'hFF, 0, 0);
            step();
            if (k < 15) chk($sformatf("auto_beat%0d_out_valid", k), int'(out_valid), 0);
        end
        check_out("auto_close", 0, 1, 12'hFF0, 16);
        step();
        check_out("auto_stall17", 0, 1, 12'hFF0, 16);
        drive(0, 8'h00, 0, 1);
        step();
        check_out("auto_release", 1, 0, 12'hFF0, 16);

        // Signedness of the operand extension
        drive(1, 8'hFF, 0, 0);
        step();
        drive(1, 8'h02, 1, 0);
        step();
        check_out("sign_ff_02", 0, 1, SIGNED_BUILD ? 1 : 257, 2);
        drive(0, 8'h00, 0, 1);
        step();
        for (int k = 0; k < 16; k++) begin
            drive(1, 8'h80, 0, 0);
            step();
        end
        check_out("sign_80x16", 0, 1, 12'h800, 16);
        drive(0, 8'h00, 0, 1);
        step();

        // Reset in the middle of a packet
        drive(1, 8'd50, 0, 0);
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_sum", int'(out_sum), 0);
        chk("midrst_out_count", int'(out_count), 0);
        drive(0, 8'h00, 0, 0);
        #3 rst_n = 1'b1;
        drive(1, 8'd5, 1, 0);
        step();
        check_out("after_rst_pkt", 0, 1, 5, 1);
        drive(0, 8'h00, 0, 1);
        step();
        check_out("after_rst_release", 1, 0, 5, 1);

        // Random traffic against the packet-level reference model
        pending   = 1'b0;
        hold_beat = 1'b0;
        cur_v     = 1'b0;
        cur_d     = 8'h00;
        cur_l     = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit exp_rdy, r, xfer;
            exp_rdy = !pending;
            chk("rnd_in_ready", int'(in_ready), int'(exp_rdy));
            chk("rnd_out_valid", int'(out_valid), int'(pending));
            if (pending) begin
                chk("rnd_out_sum", int'(out_sum), exp_sum);
                chk("rnd_out_count", int'(out_count), exp_cnt);
            end
            if (!hold_beat) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = 8'($urandom);
                cur_l = ($urandom_range(0, 5) == 0);
            end
            r = ($urandom_range(0, 2) != 0);
            drive(cur_v, cur_d, cur_l, r);
            xfer = cur_v && exp_rdy;
            if (pending && r) pending = 1'b0;
            if (xfer) begin
                pkt_q.push_back(beat_value(cur_d));
                if (cur_l || pkt_q.size() == 16) begin
                    int s;
                    s = 0;
                    foreach (pkt_q[j]) s += pkt_q[j];
                    exp_sum = s & 32'hFFF;
                    exp_cnt = pkt_q.size();
                    pending = 1'b1;
                    pkt_q.delete();
                end
            end
            hold_beat = cur_v && !xfer;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
